// File: rtl/vpu4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vpu4_pkg : shared constants, state type and helpers for the VPU4 KSA block |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vpu4_pkg;

    localparam int unsigned DATA_WIDTH    = 39;
    localparam int unsigned LANES         = 4;
    localparam int unsigned KEY_LANES     = 2;
    localparam int unsigned ADDR_WIDTH    = 12;
    localparam int unsigned CNT_WIDTH     = 13;
    localparam int unsigned Q_W           = 35;
    localparam int unsigned IQ_W          = 36;
    localparam int unsigned BARRETT_SHIFT = 70;

    localparam logic [Q_W-1:0]  Q0  = 35'h4_0800_0001;
    localparam logic [Q_W-1:0]  Q1  = 35'h4_0008_0001;
    localparam logic [IQ_W-1:0] IQ0 = 36'd68_186_767_610;
    localparam logic [IQ_W-1:0] IQ1 = 36'd68_717_379_643;

    localparam int unsigned BRAM_DELAY          = 1;
    localparam int unsigned COMMON_MODMUL_DELAY = 3;
    localparam int unsigned COMMON_MODADD_DELAY = 1;
    localparam int unsigned VPU4_DELAY = BRAM_DELAY + COMMON_MODMUL_DELAY + COMMON_MODADD_DELAY;

    localparam logic [3:0] MAX_LEVEL = 4'd12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } vpu4_state_t;

    function automatic logic [3:0] clamp_level(input logic [3:0] lvl);
        return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vpu4_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vpu4_if : start/done control plus BRAM read/write bus of the VPU4 block    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface vpu4_if;
    import vpu4_pkg::*;

    logic                              i_vpu4_start;
    logic                              i_vpu4_acc;
    logic [3:0]                        i_vpu4_level;
    logic                              o_vpu4_done;
    logic [LANES*DATA_WIDTH-1:0]       i_vpu4_dina;
    logic [LANES*DATA_WIDTH-1:0]       i_vpu4_dinb;
    logic [KEY_LANES*DATA_WIDTH-1:0]   i_vpu4_dinc;
    logic [LANES*DATA_WIDTH-1:0]       o_vpu4_dout;
    logic                              o_vpu4_rdena;
    logic                              o_vpu4_rdenb;
    logic                              o_vpu4_rdenc;
    logic [ADDR_WIDTH-1:0]             o_vpu4_rdaddra;
    logic [ADDR_WIDTH-1:0]             o_vpu4_rdaddrb;
    logic [ADDR_WIDTH-1:0]             o_vpu4_rdaddrc;
    logic                              o_vpu4_wren;
    logic [7:0]                        o_vpu4_wben;
    logic [ADDR_WIDTH-1:0]             o_vpu4_wraddr;

    modport master (
        output i_vpu4_start, i_vpu4_acc, i_vpu4_level,
        output i_vpu4_dina, i_vpu4_dinb, i_vpu4_dinc,
        input  o_vpu4_done, o_vpu4_dout,
        input  o_vpu4_rdena, o_vpu4_rdenb, o_vpu4_rdenc,
        input  o_vpu4_rdaddra, o_vpu4_rdaddrb, o_vpu4_rdaddrc,
        input  o_vpu4_wren, o_vpu4_wben, o_vpu4_wraddr
    );

    modport slave (
        input  i_vpu4_start, i_vpu4_acc, i_vpu4_level,
        input  i_vpu4_dina, i_vpu4_dinb, i_vpu4_dinc,
        output o_vpu4_done, o_vpu4_dout,
        output o_vpu4_rdena, o_vpu4_rdenb, o_vpu4_rdenc,
        output o_vpu4_rdaddra, o_vpu4_rdaddrb, o_vpu4_rdaddrc,
        output o_vpu4_wren, o_vpu4_wben, o_vpu4_wraddr
    );

endinterface
`default_nettype wire

// File: rtl/vpu4_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vpu4_datapath : one lane of (A + B*C) mod MOD, Barrett modmul then modadd  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vpu4_datapath
    import vpu4_pkg::*;
#(
    parameter logic [Q_W-1:0]  MOD    = Q0,
    parameter logic [IQ_W-1:0] IMOD   = IQ0,
    parameter int unsigned     DWIDTH = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic              i_acc,
    input  logic [DWIDTH-1:0] i_a,
    input  logic [DWIDTH-1:0] i_b,
    input  logic [DWIDTH-1:0] i_c,
    output logic [DWIDTH-1:0] o_res
);

    localparam int unsigned XW = 2 * DWIDTH;
    localparam int unsigned PW = XW + IQ_W;

    logic [2:0]        vld_q, vld_d;
    logic [XW-1:0]     x_q, x_d;
    logic [XW-1:0]     x2_q, x2_d;
    logic [IQ_W-1:0]   qhat_q, qhat_d;
    logic [DWIDTH-1:0] prod_q, prod_d;
    logic [DWIDTH-1:0] res_q, res_d;
    logic [IQ_W-1:0]   r_w;
    logic [DWIDTH:0]   sum_w;

    // qhat = floor(x*IMOD / 2^70) undershoots by at most one, so r < 2*MOD needs one subtract
    always_comb begin
        vld_d  = {vld_q[1:0], i_vld};
        x_d    = x_q;
        x2_d   = x2_q;
        qhat_d = qhat_q;
        prod_d = prod_q;
        res_d  = res_q;
        r_w    = '0;
        sum_w  = '0;
        if (i_vld) begin
            x_d = XW'(i_b) * XW'(i_c);
        end
        if (vld_q[0]) begin
            x2_d   = x_q;
            qhat_d = IQ_W'((PW'(x_q) * PW'(IMOD)) >> BARRETT_SHIFT);
        end
        if (vld_q[1]) begin
            r_w    = IQ_W'(x2_q - XW'(qhat_q) * XW'(MOD));
            prod_d = DWIDTH'((r_w >= IQ_W'(MOD)) ? (r_w - IQ_W'(MOD)) : r_w);
        end
        if (vld_q[2]) begin
            sum_w = (DWIDTH+1)'(prod_q) + (DWIDTH+1)'(i_acc ? i_a : '0);
            res_d = DWIDTH'((sum_w >= (DWIDTH+1)'(MOD)) ? (sum_w - (DWIDTH+1)'(MOD)) : sum_w);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            x_q    <= '0;
            x2_q   <= '0;
            qhat_q <= '0;
            prod_q <= '0;
            res_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            x_q    <= x_d;
            x2_q   <= x2_d;
            qhat_q <= qhat_d;
            prod_q <= prod_d;
            res_q  <= res_d;
        end
    end

    assign o_res = res_q;

endmodule
`default_nettype wire

// File: rtl/vpu4_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vpu4_top : KSA sequencer, out = (A + B*C) mod Qi over four RNS lanes       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vpu4_top
    import vpu4_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    vpu4_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] MUL_CNT = CNT_WIDTH'(COMMON_MODMUL_DELAY);
    localparam logic [CNT_WIDTH-1:0] D_CNT   = CNT_WIDTH'(VPU4_DELAY);

    vpu4_state_t            state_q, state_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   acc_q, acc_d;
    logic [3:0]             level_q, level_d;
    logic [VPU4_DELAY-1:0]  vsr_q, vsr_d;

    logic                   busy_w;
    logic [CNT_WIDTH-1:0]   n_w;
    logic [CNT_WIDTH-1:0]   off_w;
    logic                   rdena_w;
    logic                   rdenb_w;
    logic                   wren_w;
    logic [LANES*DATA_WIDTH-1:0] dout_w;

    assign busy_w  = (state_q == ST_BUSY);
    assign n_w     = 13'd4096 >> level_q;
    assign off_w   = 13'd4096 - n_w;
    assign rdenb_w = busy_w && (count_q < n_w);
    assign rdena_w = busy_w && acc_q && (count_q >= MUL_CNT) && (count_q < MUL_CNT + n_w);
    // The oldest tap of the B-read history lines up with the result leaving the adder
    assign wren_w  = vsr_q[VPU4_DELAY-1];

    always_comb begin
        state_d = state_q;
        count_d = '0;
        acc_d   = acc_q;
        level_d = level_q;
        vsr_d   = {vsr_q[VPU4_DELAY-2:0], rdenb_w};
        case (state_q)
            ST_IDLE: begin
                if (bus.i_vpu4_start) begin
                    state_d = ST_BUSY;
                    acc_d   = bus.i_vpu4_acc;
                    level_d = clamp_level(bus.i_vpu4_level);
                end
            end
            ST_BUSY: begin
                if (count_q == n_w + D_CNT) begin
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q + 13'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            acc_q   <= 1'b0;
            level_q <= '0;
            vsr_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            level_q <= level_d;
            vsr_q   <= vsr_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam logic [Q_W-1:0]  LMOD  = (i < 2) ? Q0 : Q1;
        localparam logic [IQ_W-1:0] LIMOD = (i < 2) ? IQ0 : IQ1;
        vpu4_datapath #(
            .MOD    (LMOD),
            .IMOD   (LIMOD),
            .DWIDTH (DATA_WIDTH)
        ) u_dp (
            .clk   (clk),
            .rst_n (rst_n),
            .i_vld (vsr_q[BRAM_DELAY-1]),
            .i_acc (acc_q),
            .i_a   (bus.i_vpu4_dina[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_b   (bus.i_vpu4_dinb[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_c   (bus.i_vpu4_dinc[(i/2)*DATA_WIDTH +: DATA_WIDTH]),
            .o_res (dout_w[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign bus.o_vpu4_done    = (state_q == ST_IDLE);
    assign bus.o_vpu4_dout    = dout_w;
    assign bus.o_vpu4_rdena   = rdena_w;
    assign bus.o_vpu4_rdenb   = rdenb_w;
    assign bus.o_vpu4_rdenc   = rdenb_w;
    assign bus.o_vpu4_rdaddra = rdena_w ? ADDR_WIDTH'(count_q - MUL_CNT + off_w) : '0;
    assign bus.o_vpu4_rdaddrb = rdenb_w ? ADDR_WIDTH'(count_q + off_w) : '0;
    assign bus.o_vpu4_rdaddrc = rdenb_w ? ADDR_WIDTH'(count_q + off_w) : '0;
    assign bus.o_vpu4_wren    = wren_w;
    assign bus.o_vpu4_wben    = {8{wren_w}};
    assign bus.o_vpu4_wraddr  = wren_w ? ADDR_WIDTH'(count_q - D_CNT + off_w) : '0;

endmodule
`default_nettype wire

// File: tb/tb_vpu4_top.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vpu4_top : directed checks of the VPU4 KSA block against a BRAM model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_vpu4_top;
    import vpu4_pkg::*;

    localparam int    DW  = 39;
    localparam int    MUL = 3;
    localparam int    D   = 5;
    localparam longint TQ0 = 64'h4_0800_0001;
    localparam longint TQ1 = 64'h4_0008_0001;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vpu4_if bus ();
    vpu4_top dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [4*DW-1:0] mem_a [0:4095];
    logic [4*DW-1:0] mem_b [0:4095];
    logic [2*DW-1:0] mem_c [0:4095];
    logic [4*DW-1:0] res   [0:4095];

    always @(posedge clk) begin
        if (bus.o_vpu4_rdena) bus.i_vpu4_dina <= mem_a[bus.o_vpu4_rdaddra];
        if (bus.o_vpu4_rdenb) bus.i_vpu4_dinb <= mem_b[bus.o_vpu4_rdaddrb];
        if (bus.o_vpu4_rdenc) bus.i_vpu4_dinc <= mem_c[bus.o_vpu4_rdaddrc];
    end

    int n_vec, n_err;
    int busy_cyc, wr_cnt, first_wr, last_wr, min_addr, max_addr, ra_cnt, first_ra, addr_err, timeout, bad;

    function automatic logic [4*DW-1:0] p4(input longint l0, input longint l1, input longint l2, input longint l3);
        return {DW'(l3), DW'(l2), DW'(l1), DW'(l0)};
    endfunction

    function automatic logic [2*DW-1:0] p2(input longint l0, input longint l1);
        return {DW'(l1), DW'(l0)};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] lvl, input logic acc, input int kill_at, input int poke0, input int poke1);
        int cyc;
        for (int k = 0; k < 4096; k++) res[k] = '0;
        wr_cnt = 0; first_wr = -1; last_wr = -1; min_addr = 4096; max_addr = -1;
        ra_cnt = 0; first_ra = -1; addr_err = 0; timeout = 0;
        bus.i_vpu4_level = lvl;
        bus.i_vpu4_acc   = acc;
        bus.i_vpu4_start = 1'b1;
        @(negedge clk);
        bus.i_vpu4_start = 1'b0;
        cyc = 0;
        while (1) begin
            if (bus.o_vpu4_wren) begin
                res[bus.o_vpu4_wraddr] = bus.o_vpu4_dout;
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (int'(bus.o_vpu4_wraddr) < min_addr) min_addr = int'(bus.o_vpu4_wraddr);
                if (int'(bus.o_vpu4_wraddr) > max_addr) max_addr = int'(bus.o_vpu4_wraddr);
            end else if (bus.o_vpu4_wraddr != '0) addr_err++;
            if (bus.o_vpu4_rdena) begin
                ra_cnt++;
                if (first_ra < 0) first_ra = cyc;
            end else if (bus.o_vpu4_rdaddra != '0) addr_err++;
            if (!bus.o_vpu4_rdenb && bus.o_vpu4_rdaddrb != '0) addr_err++;
            if (cyc == kill_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                break;
            end
            if (cyc == poke0 || cyc == poke1) begin
                bus.i_vpu4_start = 1'b1;
                bus.i_vpu4_level = 4'd0;
                bus.i_vpu4_acc   = 1'b0;
            end else begin
                bus.i_vpu4_start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (bus.o_vpu4_done) break;
            if (cyc > 10000) begin
                timeout = 1;
                break;
            end
        end
        bus.i_vpu4_start = 1'b0;
        busy_cyc = cyc;
        chk("run_timeout", timeout, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.i_vpu4_start = 1'b0;
        bus.i_vpu4_acc   = 1'b0;
        bus.i_vpu4_level = 4'd0;
        for (int k = 0; k < 4096; k++) begin
            mem_a[k] = '0; mem_b[k] = '0; mem_c[k] = '0;
        end
        repeat (3) @(negedge clk);

        chk("rst_done", int'(bus.o_vpu4_done), 1);
        chk("rst_wren", int'(bus.o_vpu4_wren), 0);
        chk("rst_rden", int'({bus.o_vpu4_rdena, bus.o_vpu4_rdenb, bus.o_vpu4_rdenc}), 0);
        chk("rst_addr", int'(bus.o_vpu4_wraddr) + int'(bus.o_vpu4_rdaddrb) + int'(bus.o_vpu4_rdaddra), 0);
        chk("rst_wben", int'(bus.o_vpu4_wben), 0);
        chk_d("rst_dout", bus.o_vpu4_dout, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single-element run at level 12
        mem_a[4095] = p4(1, 1, 1, 1);
        mem_b[4095] = p4(2, 2, 2, 2);
        mem_c[4095] = p2(3, 3);
        run(4'd12, 1'b1, -1, -1, -1);
        chk_d("t1_dout", res[4095], p4(7, 7, 7, 7));
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_wr_at", first_wr, D);
        chk("t1_wraddr", max_addr, 4095);
        chk("t1_busy", busy_cyc, 1 + D + 1);
        chk("t1_ra_cnt", ra_cnt, 1);
        chk("t1_ra_at", first_ra, MUL);
        chk("t1_addr_idle", addr_err, 0);

        // 2: modular boundaries
        mem_a[4095] = p4(0, 0, 0, 0);
        mem_b[4095] = p4(TQ0 - 1, TQ0 - 1, TQ1 - 1, TQ1 - 1);
        mem_c[4095] = p2(TQ0 - 1, TQ1 - 1);
        run(4'd12, 1'b1, -1, -1, -1);
        chk_d("t2_sq", res[4095], p4(1, 1, 1, 1));
        mem_a[4095] = p4(TQ0 - 1, TQ0 - 1, TQ1 - 1, TQ1 - 1);
        mem_b[4095] = p4(1, 1, 1, 1);
        mem_c[4095] = p2(1, 1);
        run(4'd12, 1'b1, -1, -1, -1);
        chk_d("t2_wrap", res[4095], p4(0, 0, 0, 0));

        // 3: level 3, no accumulate
        for (int k = 0; k < 4096; k++) begin
            mem_a[k] = p4(5, 5, 5, 5);
            mem_b[k] = p4(4, 4, 4, 4);
            mem_c[k] = p2(6, 6);
        end
        run(4'd3, 1'b0, -1, -1, -1);
        bad = 0;
        for (int k = 3584; k < 4096; k++) if (res[k] !== p4(24, 24, 24, 24)) bad++;
        chk("t3_data_bad", bad, 0);
        chk("t3_wr_cnt", wr_cnt, 512);
        chk("t3_min_addr", min_addr, 3584);
        chk("t3_max_addr", max_addr, 4095);
        chk("t3_ra_cnt", ra_cnt, 0);
        chk("t3_busy", busy_cyc, 512 + D + 1);
        chk("t3_addr_idle", addr_err, 0);

        // 6: stray starts while busy, then a back-to-back start
        run(4'd12, 1'b1, -1, 5, 1 + D);
        chk_d("t6_dout", res[4095], p4(29, 29, 29, 29));
        chk("t6_wr_cnt", wr_cnt, 1);
        chk("t6_busy", busy_cyc, 1 + D + 1);
        run(4'd3, 1'b1, -1, -1, -1);
        bad = 0;
        for (int k = 3584; k < 4096; k++) if (res[k] !== p4(29, 29, 29, 29)) bad++;
        chk("t6b_data_bad", bad, 0);
        chk("t6b_wr_cnt", wr_cnt, 512);
        chk("t6b_busy", busy_cyc, 512 + D + 1);

        // 4: full ramp at level 0; 3k stays below both moduli
        for (int k = 0; k < 4096; k++) begin
            mem_a[k] = p4(k, k, k, k);
            mem_b[k] = p4(k, k, k, k);
            mem_c[k] = p2(2, 2);
        end
        run(4'd0, 1'b1, -1, -1, -1);
        bad = 0;
        for (int k = 0; k < 4096; k++) if (res[k] !== p4(3 * k, 3 * k, 3 * k, 3 * k)) bad++;
        chk("t4_data_bad", bad, 0);
        chk("t4_wr_cnt", wr_cnt, 4096);
        chk("t4_contig", last_wr - first_wr + 1, 4096);
        chk("t4_wr_at", first_wr, D);
        chk("t4_busy", busy_cyc, 4096 + D + 1);
        chk("t4_ra_cnt", ra_cnt, 4096);
        chk("t4_min_addr", min_addr, 0);
        chk("t4_addr_idle", addr_err, 0);

        // 5: reset at count 100, then a clean full run
        run(4'd0, 1'b1, 100, -1, -1);
        chk("t5_done", int'(bus.o_vpu4_done), 1);
        chk("t5_rden", int'({bus.o_vpu4_rdena, bus.o_vpu4_rdenb, bus.o_vpu4_rdenc}), 0);
        chk("t5_wren", int'(bus.o_vpu4_wren), 0);
        chk("t5_rdaddrb", int'(bus.o_vpu4_rdaddrb), 0);
        chk("t5_wr_before", wr_cnt, 96);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_vpu4_wren || !bus.o_vpu4_done) bad++;
        end
        chk("t5_quiet", bad, 0);
        run(4'd0, 1'b1, -1, -1, -1);
        bad = 0;
        for (int k = 0; k < 4096; k++) if (res[k] !== p4(3 * k, 3 * k, 3 * k, 3 * k)) bad++;
        chk("t5_data_bad", bad, 0);
        chk("t5_wr_cnt", wr_cnt, 4096);
        chk("t5_busy", busy_cyc, 4096 + D + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
